pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL provide: CLK  input  1  sole clock; all state on its rising edge.
REQ-002 SHALL provide: RESET_N  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide: DE_V  input  1  decode holds a valid instruction.
REQ-004 SHALL provide: DE_IR  input  32  instruction in decode.
REQ-005 SHALL provide: WB_V  input  1  writeback retires a register write this cycle.
REQ-006 SHALL provide: WB_DR  input  5  writeback destination register.
REQ-007 SHALL provide: KILL_V  input  1  one in-flight instruction squashed this cycle.
REQ-008 SHALL provide: KILL_DR  input  5  destination of the squashed instruction.
REQ-009 SHALL provide: STALL  output  1  decode must hold DE_IR.
REQ-010 SHALL provide: ISSUE  output  1  DE_IR accepted this cycle.
REQ-011 SHALL provide: STALL_CAUSE  output  2  0 none, 1 RAW, 2 WAW-saturation, 3 drain.
REQ-012 SHALL provide: BUSY_MASK  output  32  bit n set when register n has a pending write.
REQ-013 SHALL provide: ERR  output  1  sticky counter-underflow flag.

Function
REQ-014 SHALL keep a 2-bit pending counter per register x1..x31; x0 never tracked, never causes a hazard.
REQ-015 SHALL decode register usage from DE_IR[6:0]: 0000011 rs1,rd; 0100011 rs1,rs2; 0110011 rs1,rs2,rd; 0010011 rs1,rd; 1100011 rs1,rs2; 0110111/0010111 rd; 1101111 rd; 1100111 rs1,rd; 0001111/1110011 drain-class, no registers; other opcodes use no registers.
REQ-016 SHALL compute effective count = stored count minus 1 when WB_V and WB_DR match (writeback bypass), used only for hazard check.
REQ-017 SHALL assert RAW stall when DE_V and any used source has effective count nonzero.
REQ-018 SHALL assert WAW-saturation stall when DE_V, rd used, nonzero, and stored count of rd is 3.
REQ-019 SHALL run FSM states RUN and DRAIN; RUN->DRAIN when a drain-class instruction is in decode and any counter nonzero; DRAIN->RUN in the cycle all counters read zero; drain-class with all counters zero issues in RUN directly.
REQ-020 SHALL drive STALL combinationally, priority drain > RAW > WAW; STALL_CAUSE encodes the winning cause, 0 when not stalled.
REQ-021 SHALL drive ISSUE = DE_V and not STALL, zero-cycle latency.
REQ-022 SHALL on ISSUE with rd used and nonzero increment counter of rd at the next edge.
REQ-023 SHALL decrement counter of WB_DR on WB_V and of KILL_DR on KILL_V; x0 events ignored.
REQ-024 SHALL net all simultaneous events per register (e.g. issue+WB same rd leaves count unchanged; WB+KILL same register subtracts 2).
REQ-025 SHALL clamp any decrement below 0 to 0 and set ERR, which holds until reset.
REQ-026 SHALL drive BUSY_MASK from stored counters, bit 0 always 0.
REQ-027 SHALL ignore DE_IR contents when DE_V is low: STALL=0, ISSUE=0.

Reset
REQ-028 SHALL on RESET_N low immediately clear all counters, ERR, BUSY_MASK; FSM to RUN; STALL, ISSUE, STALL_CAUSE follow to 0 with DE_V low.
REQ-029 SHALL discard in-flight state when reset asserts mid-drain; no pending counts survive.

Structure
REQ-030 SHALL take opcode constants, STALL_CAUSE encoding and FSM state enum from shared package riscv_pkg.
REQ-031 SHALL place per-register counters with netting and clamp in one sub-module, sb_counter_array.

Verification
REQ-032 SHALL test: issue add x5 (0110011, rd=5), next cycle add rs1=5 -> STALL=1, STALL_CAUSE=1 until WB_V with WB_DR=5, that cycle ISSUE=1.
REQ-033 SHALL test: three issues writing x7, fourth writing x7 -> STALL_CAUSE=2; one WB of x7 -> stall stays (count 2, stored 3 prior edge clears next cycle), fourth issues after.
REQ-034 SHALL test: pending x3, FENCE (0001111) in decode -> STALL_CAUSE=3, FSM DRAIN; WB x3 -> RUN, ISSUE=1 next cycle.
REQ-035 SHALL test: issue writing x9 and WB_DR=9 same cycle with count 1 -> count stays 1, BUSY_MASK[9]=1.
REQ-036 SHALL test: WB_V with WB_DR=4 while count 0 -> ERR=1, count stays 0; RESET_N low -> ERR=0.
REQ-037 SHALL test: instruction writing x0 and reading x0 -> never stalls, BUSY_MASK stays 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants, stall-cause encoding and hazard FSM states
// used by the scoreboard-style hazard controller.
package riscv_pkg;

  localparam int NUM_REGS = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_RAW   = 2'd1,
    CAUSE_WAW   = 2'd2,
    CAUSE_DRAIN = 2'd3
  } stall_cause_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic rs1;
    logic rs2;
    logic rd;
    logic drain;
  } reg_use_t;

  // Which register fields an opcode actually reads/writes; unknown opcodes use none.
  function automatic reg_use_t decode_use(input logic [6:0] opcode);
    reg_use_t u;
    u = '0;
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_JALR: begin u.rs1 = 1'b1; u.rd = 1'b1; end
      OP_STORE, OP_BRANCH:         begin u.rs1 = 1'b1; u.rs2 = 1'b1; end
      OP_OP:                       begin u.rs1 = 1'b1; u.rs2 = 1'b1; u.rd = 1'b1; end
      OP_LUI, OP_AUIPC, OP_JAL:    u.rd = 1'b1;
      OP_FENCE, OP_SYSTEM:         u.drain = 1'b1;
      default:                     u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/sb_counter_array.sv
// Per-register 2-bit pending-write counters; nets issue/writeback/kill events
// per register each cycle and clamps underflow to zero with a sticky error.
module sb_counter_array
  import riscv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        inc_v,
  input  logic [4:0]  inc_dr,
  input  logic        wb_v,
  input  logic [4:0]  wb_dr,
  input  logic        kill_v,
  input  logic [4:0]  kill_dr,
  output logic [63:0] counts,
  output logic        err
);

  logic [1:0]          cnt_q [NUM_REGS];
  logic [1:0]          cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] under;

  always_comb begin
    logic [2:0] up;
    logic [2:0] dn;
    up = '0;
    dn = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      up = {1'b0, cnt_q[r]} + {2'b00, inc_v && (inc_dr == 5'(r))};
      dn = {2'b00, wb_v && (wb_dr == 5'(r))} + {2'b00, kill_v && (kill_dr == 5'(r))};
      under[r] = 1'b0;
      cnt_d[r] = 2'd0;
      // x0 is never tracked, so its events neither count nor flag underflow.
      if (r != 0) begin
        if (up < dn)
          under[r] = 1'b1;
        else if ((up - dn) > 3'd3)
          cnt_d[r] = 2'd3;
        else
          cnt_d[r] = 2'(up - dn);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 2'd0;
      err <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      if (|under) err <= 1'b1;
    end
  end

  always_comb begin
    counts = '0;
    for (int r = 0; r < NUM_REGS; r++) counts[2*r +: 2] = cnt_q[r];
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage hazard controller: scoreboards pending register writes and
// stalls decode on RAW, WAW counter saturation, or drain-class instructions.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        DE_V,
  input  logic [31:0] DE_IR,
  input  logic        WB_V,
  input  logic [4:0]  WB_DR,
  input  logic        KILL_V,
  input  logic [4:0]  KILL_DR,
  output logic        STALL,
  output logic        ISSUE,
  output logic [1:0]  STALL_CAUSE,
  output logic [31:0] BUSY_MASK,
  output logic        ERR,
  output logic        DBG_STATE
);

  // Handshake: decode presents DE_IR with DE_V high and holds it while STALL=1;
  // the instruction is consumed in exactly the cycle ISSUE=1 (DE_V && !STALL).

  logic [6:0]   opcode;
  logic [4:0]   rd, rs1, rs2;
  reg_use_t     use_d;
  logic [63:0]  counts;
  logic [1:0]   cnt_rs1, cnt_rs2, cnt_rd;
  logic         rs1_hot, rs2_hot;
  logic         raw_hit, waw_hit, drain_hit, any_busy, inc_v;
  stall_cause_e cause;
  hz_state_e    state_q, state_d;
  logic         unused_ir_bits;

  assign opcode = DE_IR[6:0];
  assign rd     = DE_IR[11:7];
  assign rs1    = DE_IR[19:15];
  assign rs2    = DE_IR[24:20];
  assign unused_ir_bits = ^{DE_IR[31:25], DE_IR[14:12]};
  assign use_d  = decode_use(opcode);

  assign cnt_rs1 = counts[{rs1, 1'b0} +: 2];
  assign cnt_rs2 = counts[{rs2, 1'b0} +: 2];
  assign cnt_rd  = counts[{rd, 1'b0} +: 2];

  // A same-cycle writeback retires one pending write before the source check.
  assign rs1_hot = (rs1 != 5'd0) && (cnt_rs1 > {1'b0, WB_V && (WB_DR == rs1)});
  assign rs2_hot = (rs2 != 5'd0) && (cnt_rs2 > {1'b0, WB_V && (WB_DR == rs2)});

  assign any_busy  = |BUSY_MASK;
  assign raw_hit   = DE_V && ((use_d.rs1 && rs1_hot) || (use_d.rs2 && rs2_hot));
  assign waw_hit   = DE_V && use_d.rd && (rd != 5'd0) && (cnt_rd == 2'd3);
  assign drain_hit = DE_V && use_d.drain && any_busy;

  always_comb begin
    state_d = state_q;
    cause   = CAUSE_NONE;
    case (state_q)
      ST_RUN:   if (drain_hit) state_d = ST_DRAIN;
      ST_DRAIN: if (!any_busy) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (drain_hit)     cause = CAUSE_DRAIN;
    else if (raw_hit)  cause = CAUSE_RAW;
    else if (waw_hit)  cause = CAUSE_WAW;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  assign STALL_CAUSE = cause;
  assign STALL       = (cause != CAUSE_NONE);
  assign ISSUE       = DE_V && !STALL;
  assign inc_v       = ISSUE && use_d.rd && (rd != 5'd0);
  assign DBG_STATE   = state_q;

  always_comb begin
    BUSY_MASK = '0;
    for (int r = 1; r < NUM_REGS; r++) BUSY_MASK[r] = |counts[2*r +: 2];
  end

  sb_counter_array u_counters (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc_v   (inc_v),
    .inc_dr  (rd),
    .wb_v    (WB_V),
    .wb_dr   (WB_DR),
    .kill_v  (KILL_V),
    .kill_dr (KILL_DR),
    .counts  (counts),
    .err     (ERR)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// scored per cycle against a register-count reference model.
module tb_pipeline_hazard_ctrl;

  localparam int W = 38;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        DE_V;
  logic [31:0] DE_IR;
  logic        WB_V;
  logic [4:0]  WB_DR;
  logic        KILL_V;
  logic [4:0]  KILL_DR;
  logic        STALL, ISSUE, ERR, DBG_STATE;
  logic [1:0]  STALL_CAUSE;
  logic [31:0] BUSY_MASK;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int          m_cnt [32];
  bit          m_err;
  bit          m_drain;
  bit          last_stall;
  logic [31:0] last_ir;
  logic [6:0]  ops [12];

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RESET_N(RESET_N), .DE_V(DE_V), .DE_IR(DE_IR),
    .WB_V(WB_V), .WB_DR(WB_DR), .KILL_V(KILL_V), .KILL_DR(KILL_DR),
    .STALL(STALL), .ISSUE(ISSUE), .STALL_CAUSE(STALL_CAUSE),
    .BUSY_MASK(BUSY_MASK), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    return {7'b0, 5'(rs2), 5'(rs1), 3'b0, 5'(rd), op};
  endfunction

  function automatic void uses(input logic [6:0] op, output bit s1, output bit s2, output bit d, output bit dr);
    s1 = 0; s2 = 0; d = 0; dr = 0;
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: begin s1 = 1; d = 1; end
      7'b0100011, 7'b1100011:             begin s1 = 1; s2 = 1; end
      7'b0110011:                         begin s1 = 1; s2 = 1; d = 1; end
      7'b0110111, 7'b0010111, 7'b1101111: d = 1;
      7'b0001111, 7'b1110011:             dr = 1;
      default: ;
    endcase
  endfunction

  function automatic bit src_pending(input int r, input bit wv, input logic [4:0] wdr);
    int eff;
    if (r == 0) return 0;
    eff = m_cnt[r] - ((wv && wdr == 5'(r)) ? 1 : 0);
    return eff > 0;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;
    m_drain = 0;
    last_stall = 0;
  endtask

  // Drive one cycle of inputs, queue this cycle's expected outputs, then advance the model.
  task automatic drive(input bit dv, input logic [31:0] ir, input bit wv, input logic [4:0] wdr,
                       input bit kv, input logic [4:0] kdr);
    bit s1, s2, d, dr, raw, waw, drn, stall, issue;
    int rd, rs1, rs2, cause, v;
    logic [31:0] busy;
    @(posedge CLK); #1;
    DE_V = dv; DE_IR = ir; WB_V = wv; WB_DR = wdr; KILL_V = kv; KILL_DR = kdr;
    uses(ir[6:0], s1, s2, d, dr);
    rd = int'(ir[11:7]); rs1 = int'(ir[19:15]); rs2 = int'(ir[24:20]);
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (m_cnt[r] > 0);
    raw = dv && ((s1 && src_pending(rs1, wv, wdr)) || (s2 && src_pending(rs2, wv, wdr)));
    waw = dv && d && rd != 0 && m_cnt[rd] == 3;
    drn = dv && dr && (busy != 0);
    cause = drn ? 3 : raw ? 1 : waw ? 2 : 0;
    stall = (cause != 0);
    issue = dv && !stall;
    exp_q.push_back({m_drain, m_err, busy, 2'(cause), issue, stall});
    for (int r = 1; r < 32; r++) begin
      v = m_cnt[r] + ((issue && d && rd == r) ? 1 : 0)
                   - ((wv && wdr == 5'(r)) ? 1 : 0) - ((kv && kdr == 5'(r)) ? 1 : 0);
      if (v < 0) begin v = 0; m_err = 1; end
      m_cnt[r] = v;
    end
    m_drain = m_drain ? (busy != 0) : drn;
    last_stall = stall;
    last_ir = ir;
  endtask

  task automatic idle(input bit wv = 0, input int wdr = 0);
    drive(0, 32'h0, wv, 5'(wdr), 0, 5'd0);
  endtask

  task automatic at_mid();
    @(negedge CLK); #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    at_mid();
    if (exp_q.size() != 0) check("queue_before_reset", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    RESET_N = 0; DE_V = 0; WB_V = 0; KILL_V = 0;
    #1;
    check("reset_outputs", 64'({DBG_STATE, ERR, BUSY_MASK, STALL_CAUSE, ISSUE, STALL}), 64'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1;
    model_reset();
  endtask

  // Monitor: every cycle that has a queued expectation is compared mid-cycle.
  initial begin
    logic [W-1:0] e, got;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {DBG_STATE, ERR, BUSY_MASK, STALL_CAUSE, ISSUE, STALL};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL cycle_outputs t=%0t got st=%0d err=%0d busy=%h cause=%0d iss=%0d stall=%0d exp st=%0d err=%0d busy=%h cause=%0d iss=%0d stall=%0d",
                   $time, got[37], got[36], got[35:4], got[3:2], got[1], got[0],
                   e[37], e[36], e[35:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    logic [6:0] op;
    logic [31:0] ir;
    bit dv, wv, kv;
    int wdr, kdr, n;
    int pend[$];
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111, 7'b1110011, 7'b1010111};
    DE_V = 0; DE_IR = 0; WB_V = 0; WB_DR = 0; KILL_V = 0; KILL_DR = 0;
    RESET_N = 1;
    model_reset();
    #2;
    do_reset();

    // x0 as source and destination never stalls or becomes busy
    drive(1, mk(7'b0110011, 0, 0, 0), 1, 5'd0, 0, 5'd0);
    drive(1, mk(7'b0110011, 0, 0, 0), 0, 5'd0, 1, 5'd0);
    at_mid();
    check("x0_no_hazard", 64'({STALL, ISSUE, BUSY_MASK, ERR}), 64'({1'b0, 1'b1, 32'h0, 1'b0}));

    // RAW on x5 until its writeback
    drive(1, mk(7'b0110011, 5, 0, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b0110011, 1, 5, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("raw_stall", 64'({STALL, STALL_CAUSE}), 64'(3'b101));
    drive(1, mk(7'b0110011, 1, 5, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b0110011, 1, 5, 0), 1, 5'd5, 0, 5'd0);
    at_mid();
    check("raw_wb_issue", 64'({STALL, ISSUE}), 64'(2'b01));
    idle(1, 1);

    // WAW saturation on x7
    repeat (3) drive(1, mk(7'b0110111, 7, 0, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b0110111, 7, 0, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("waw_stall", 64'({STALL, STALL_CAUSE}), 64'(3'b110));
    drive(1, mk(7'b0110111, 7, 0, 0), 1, 5'd7, 0, 5'd0);
    at_mid();
    check("waw_stall_wb", 64'({STALL, STALL_CAUSE}), 64'(3'b110));
    drive(1, mk(7'b0110111, 7, 0, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("waw_issue", 64'({STALL, ISSUE}), 64'(2'b01));
    idle();
    at_mid();
    check("waw_busy7", 64'(BUSY_MASK), 64'(32'h80));
    repeat (3) idle(1, 7);

    // FENCE drains pending x3
    drive(1, mk(7'b0010011, 3, 0, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b0001111, 0, 0, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("drain_stall", 64'({STALL, STALL_CAUSE}), 64'(3'b111));
    drive(1, mk(7'b0001111, 0, 0, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("drain_state", 64'({DBG_STATE, STALL}), 64'(2'b11));
    drive(1, mk(7'b0001111, 0, 0, 0), 1, 5'd3, 0, 5'd0);
    drive(1, mk(7'b0001111, 0, 0, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("drain_issue", 64'({STALL, ISSUE}), 64'(2'b01));
    idle();
    at_mid();
    check("drain_back_run", 64'(DBG_STATE), 64'd0);

    // issue and writeback of x9 in the same cycle net to zero
    drive(1, mk(7'b1101111, 9, 0, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b1101111, 9, 0, 0), 1, 5'd9, 0, 5'd0);
    idle();
    at_mid();
    check("net_busy9", 64'(BUSY_MASK), 64'(32'h200));
    idle(1, 9);
    idle();
    at_mid();
    check("net_clear9", 64'(BUSY_MASK), 64'd0);

    // underflow on x4 sets sticky ERR, cleared only by reset
    idle(1, 4);
    idle();
    at_mid();
    check("underflow_err", 64'({ERR, BUSY_MASK}), 64'({1'b1, 32'h0}));
    do_reset();

    // reset in the middle of a drain leaves nothing pending
    drive(1, mk(7'b0000011, 3, 0, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b1110011, 0, 0, 0), 0, 5'd0, 0, 5'd0);
    drive(1, mk(7'b1110011, 0, 0, 0), 0, 5'd0, 0, 5'd0);
    do_reset();
    drive(1, mk(7'b1110011, 0, 0, 0), 0, 5'd0, 0, 5'd0);
    at_mid();
    check("post_reset_issue", 64'({STALL, ISSUE, DBG_STATE}), 64'(3'b010));

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 == 499) do_reset();
      dv = ($urandom_range(0, 3) != 0);
      if (last_stall && $urandom_range(0, 3) != 0) begin
        ir = last_ir;
        dv = 1;
      end else begin
        op = ops[$urandom_range(0, 11)];
        ir = $urandom;
        ir[6:0] = op;
        ir[11:7] = 5'($urandom_range(0, 7));
        ir[19:15] = 5'($urandom_range(0, 7));
        ir[24:20] = 5'($urandom_range(0, 7));
      end
      pend.delete();
      for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
      wv = 0; wdr = 0; kv = 0; kdr = 0;
      if (pend.size() > 0 && $urandom_range(0, 9) < 6) begin
        wv = 1; wdr = pend[$urandom_range(0, pend.size() - 1)];
      end else if ($urandom_range(0, 19) == 0) begin
        wv = 1; wdr = $urandom_range(0, 7);
      end
      if (pend.size() > 0 && $urandom_range(0, 9) == 0) begin
        kv = 1; kdr = pend[$urandom_range(0, pend.size() - 1)];
      end
      drive(dv, ir, wv, 5'(wdr), kv, 5'(kdr));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      at_mid();
      n++;
    end
    if (exp_q.size() > 0) check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
